vga_fb_arbiter: RTL and testbench

Single-port framebuffer arbiter between the VGA scan-out path and a pixel writer such as a drawing engine or CPU bridge. Scan-out reads have strict priority and a fixed 2-cycle latency. Writes are buffered in a small FIFO and retired in cycles when no read is issued. After reset the block clears the whole framebuffer to a constant colour before it accepts writes.

---
 rtl/vga_pkg.sv | 8 +
 rtl/vga_wr_fifo.sv | 41 ++++
 rtl/vga_fb_arbiter.sv | 136 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer definitions used by the arbiter, timing generator and drawing engine.
package vga_pkg;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 17;
  localparam logic [DATA_W-1:0] CLEAR_COLOR = 12'h000;

  typedef enum logic {CLEAR, RUN} fb_state_e;
endpackage

// File: rtl/vga_wr_fifo.sv
// Write-request buffer: synchronous FIFO with full/empty flags, combinational head.
module vga_wr_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout    = mem[rd_ptr[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads first, then post-reset clear, then buffered writes.
module vga_fb_arbiter #(
  parameter int                DATA_W       = vga_pkg::DATA_W,
  parameter int                ADDR_W       = vga_pkg::ADDR_W,
  parameter int                DEPTH        = 76800,
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR  = vga_pkg::CLEAR_COLOR,
  parameter int                STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy_clear,
  output logic              wr_starved
);
  import vga_pkg::*;

  localparam int                STAGES  = 1;
  localparam int                FW      = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam int                SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   SLIM    = SC_W'(STARVE_LIMIT);

  fb_state_e         state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_inc, pop, push;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              rd_inr, head_inr;
  logic [STAGES:0]   vld_pipe;
  logic              inr_q;
  logic [SC_W-1:0]   starve_cnt, starve_nx;

  vga_wr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_addr  = head[FW-1:DATA_W];
  assign head_data  = head[DATA_W-1:0];
  assign rd_inr     = ({1'b0, rd_addr} < DEPTH_X);
  assign head_inr   = ({1'b0, head_addr} < DEPTH_X);
  // A pop this cycle does not free a slot for this cycle's push.
  assign wr_ready   = reset && (state == RUN) && !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign busy_clear = (state == CLEAR);
  assign rd_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = rd_addr;
    mem_wdata = head_data;
    pop       = 1'b0;
    clr_inc   = 1'b0;
    if (!reset) begin
      state_nx = CLEAR;
    end else if (rd_req) begin
      mem_en = rd_inr;
    end else if (state == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_ptr;
      mem_wdata = CLEAR_COLOR;
      clr_inc   = 1'b1;
      if (clr_ptr == LAST) state_nx = RUN;
    end else if (!fifo_empty) begin
      // Out-of-range entries are retired without touching memory.
      pop      = 1'b1;
      mem_en   = head_inr;
      mem_we   = head_inr;
      mem_addr = head_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)       clr_ptr <= '0;
    else if (clr_inc) clr_ptr <= clr_ptr + 1'b1;
  end

  // Out-of-range reads still return a result, forced to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      inr_q    <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_req};
      inr_q    <= rd_inr;
      if (vld_pipe[STAGES-1]) rd_data <= inr_q ? mem_rdata : '0;
    end
  end

  always_comb begin
    starve_nx = starve_cnt;
    if (pop)                                             starve_nx = '0;
    else if (rd_req && !fifo_empty && starve_cnt != SLIM) starve_nx = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else begin
      starve_cnt <= starve_nx;
      if (starve_nx == SLIM) wr_starved <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small framebuffer and a behavioural sync RAM.
module tb_vga_fb_arbiter;
  localparam int DW = 12, AW = 17, DEPTH = 2048, IW = 11;

  logic          clk = 1'b0;
  logic          reset, rd_req, wr_valid, wr_ready, rd_valid;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy_clear, wr_starved;

  logic          pre_en;
  logic [IW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [DEPTH];

  int n_chk = 0, n_pass = 0;
  int cnt, bad, nv, nwe, pushes;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIFO_DEPTH(4),
                   .CLEAR_COLOR(12'h000), .STARVE_LIMIT(1024)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy_clear(busy_clear),
    .wr_starved(wr_starved)
  );

  // Bench-side preload port takes precedence over the DUT.
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_addr < AW'(DEPTH)) begin
      if (mem_we) ram[mem_addr[IW-1:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[IW-1:0]];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0; mem_rdata = '0;

    // Fill RAM with a non-clear pattern while reset is held.
    for (int i = 0; i < DEPTH; i++) begin
      pre_en = 1'b1; pre_addr = IW'(i); pre_data = 12'hABC; tick();
    end
    pre_en = 1'b0;
    rd_req = 1'b1; rd_addr = 17'd3; #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy_clear", busy_clear, 1);
    chk("rst_wr_starved", wr_starved, 0);
    chk("rst_mem", {mem_en, mem_we}, 2'b00);
    rd_req = 1'b0;
    tick();

    reset = 1'b1; #1;
    chk("clr_first", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 17'd0, 12'h000});
    cnt = 0; bad = 0;
    while (busy_clear === 1'b1 && cnt < DEPTH + 16) begin
      if (wr_ready !== 1'b0) bad++;
      cnt++; tick();
    end
    chk("clear_len", cnt, DEPTH);
    chk("clear_wr_ready_low", bad, 0);
    chk("run_wr_ready", wr_ready, 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 12'h000) bad++;
    chk("clear_ram", bad, 0);

    // Read latency against a value written through the FIFO.
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 12'h5A5; tick();
    wr_valid = 1'b0; #1;
    chk("wr5_retire", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 17'd5, 12'h5A5});
    tick();
    rd_req = 1'b1; rd_addr = 17'd5; #1;
    chk("rd5_issue", {mem_en, mem_we}, 2'b10);
    tick();
    rd_req = 1'b0; #1;
    chk("rd5_n1", rd_valid, 0);
    tick();
    chk("rd5_n2", {rd_valid, rd_data}, {1'b1, 12'h5A5});
    tick();
    chk("rd5_n3", rd_valid, 0);

    // 640-word scan-out burst.
    for (int i = 0; i < 640; i++) begin
      pre_en = 1'b1; pre_addr = IW'(i); pre_data = DW'(i * 37 + 11); tick();
    end
    pre_en = 1'b0;
    nv = 0; bad = 0;
    for (int c = 0; c < 644; c++) begin
      rd_req = (c < 640); rd_addr = AW'(c); #1;
      if (rd_valid === 1'b1) begin
        nv++;
        if (c < 2 || c > 641 || rd_data !== DW'((c - 2) * 37 + 11)) bad++;
      end
      tick();
    end
    rd_req = 1'b0;
    chk("burst_count", nv, 640);
    chk("burst_data", bad, 0);

    // Out-of-range read returns zero even though mem_rdata is stale non-zero.
    rd_req = 1'b1; rd_addr = AW'(DEPTH); #1;
    chk("oor_rd_mem_en", mem_en, 0);
    tick();
    rd_req = 1'b0; tick();
    chk("oor_rd_result", {rd_valid, rd_data}, {1'b1, 12'h000});

    // Out-of-range write is accepted and silently retired.
    wr_valid = 1'b1; wr_addr = 17'd80000; wr_data = 12'hFFF; #1;
    chk("oor_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0; #1;
    chk("oor_wr_mem_en", mem_en, 0);
    tick();
    wr_valid = 1'b1; wr_addr = 17'd7; wr_data = 12'h777; tick();
    wr_valid = 1'b0; #1;
    chk("after_oor_wr", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 17'd7, 12'h777});
    tick();

    // Reads hold off four buffered writes; they retire in order once reads stop.
    rd_req = 1'b1; rd_addr = 17'd10; nwe = 0; pushes = 0;
    for (int c = 0; c < 8; c++) begin
      wr_valid = (pushes < 4); wr_addr = AW'(100 + pushes); wr_data = DW'(256 + pushes); #1;
      if (mem_we === 1'b1) nwe++;
      if (wr_valid && wr_ready === 1'b1) pushes++;
      tick();
    end
    wr_valid = 1'b0;
    chk("prio_pushes", pushes, 4);
    chk("prio_no_we", nwe, 0);
    chk("prio_full_ready", wr_ready, 0);
    rd_req = 1'b0; #1;
    chk("full_pop_ready", wr_ready, 0);
    for (int k = 0; k < 4; k++) begin
      chk("prio_drain", {mem_en, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, AW'(100 + k), DW'(256 + k)});
      tick();
    end
    chk("prio_drained", mem_en, 0);

    // Starvation flag at exactly 1024 blocked cycles, sticky afterwards.
    rd_req = 1'b1; rd_addr = 17'd20; wr_valid = 1'b1; wr_addr = 17'd200; wr_data = 12'h222; tick();
    wr_valid = 1'b0;
    repeat (1023) tick();
    chk("starve_1023", wr_starved, 0);
    tick();
    chk("starve_1024", wr_starved, 1);
    rd_req = 1'b0; #1;
    chk("starve_retire", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 17'd200});
    tick(); tick();
    chk("starve_sticky", wr_starved, 1);

    // Reset with two writes queued and a read in flight.
    rd_req = 1'b1; rd_addr = 17'd5; wr_valid = 1'b1; wr_addr = 17'd300; wr_data = 12'h001; tick();
    wr_addr = 17'd301; tick();
    wr_valid = 1'b0; rd_req = 1'b0; reset = 1'b0; #1;
    chk("mid_rst_mem_en", mem_en, 0);
    tick();
    reset = 1'b1; #1;
    chk("mid_rst_no_stray", rd_valid, 0);
    chk("mid_rst_busy", busy_clear, 1);
    chk("mid_rst_starved", wr_starved, 0);
    chk("mid_rst_clr0", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 17'd0});
    repeat (1000) tick();
    chk("clr_ptr_1000", mem_addr, 1000);
    reset = 1'b0; tick();
    reset = 1'b1; #1;
    chk("clr_restart", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 17'd0});
    cnt = 0; bad = 0;
    while (busy_clear === 1'b1 && cnt < DEPTH + 16) begin
      if (rd_valid !== 1'b0) bad++;
      cnt++; tick();
    end
    chk("reclear_len", cnt, DEPTH);
    chk("reclear_no_rd_valid", bad, 0);
    chk("flushed_0", {mem_en, wr_ready}, 2'b01);
    tick();
    chk("flushed_1", {mem_en, rd_valid}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
